seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32: operand width; SHALL be a power of two, at least 8.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 clear  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 A_reg  input  WIDTH  operand A.
REQ-007 B_reg  input  WIDTH  operand B; also the shift/rotate amount.
REQ-008 opcode  input  5  operation select.
REQ-009 out_valid  output  1  C_reg and err hold a finished result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 C_reg  output  2*WIDTH  result; high half is HI, low half is LO.
REQ-012 err  output  1  divide-by-zero or illegal opcode flag, qualified by out_valid.

Function
REQ-013 Opcodes SHALL be: add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, mul 01110, div 01111, neg 10000, not 10001; all other codes are illegal.
REQ-014 FSM states SHALL be IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid and in_ready are both 1, capturing A_reg, B_reg and opcode.
REQ-016 Single-cycle operations (add, sub, shr, shl, ror, rol, and, or, neg, not) SHALL go IDLE -> DONE, with out_valid=1 on the cycle after acceptance.
REQ-017 For single-cycle operations LO = the WIDTH-bit result and HI = 0; add and sub wrap modulo 2^WIDTH.
REQ-018 neg = two's complement of B_reg; not = bitwise inverse of B_reg.
REQ-019 Shift and rotate amount = B_reg[log2(WIDTH)-1:0]; shr is logical.
REQ-020 mul SHALL be signed, WIDTH x WIDTH to 2*WIDTH bits, computed iteratively: IDLE -> BUSY for WIDTH cycles -> DONE, so out_valid rises WIDTH+1 cycles after acceptance.
REQ-021 div SHALL be signed and iterative with the same latency as mul: LO = quotient truncated toward zero, HI = remainder carrying the dividend's sign.
REQ-022 Most-negative / -1 SHALL give LO = most-negative and HI = 0, with err=0.
REQ-023 div with B_reg=0 SHALL give err=1, HI=A_reg, LO=all ones, with latency 1 (no BUSY state).
REQ-024 An illegal opcode SHALL give err=1, C_reg=0, with latency 1.
REQ-025 In DONE, C_reg, err and out_valid SHALL hold stable until out_ready=1; on that cycle the FSM returns to IDLE, and out_valid is 0 on the next cycle.
REQ-026 No request SHALL be accepted in the cycle DONE exits; in_ready rises the following cycle.
REQ-027 Inputs SHALL be ignored in BUSY and DONE; operand changes there do not affect the result.
REQ-028 In BUSY, out_valid=0 and C_reg is undefined-stable (not checked).

Reset
REQ-029 clear=1 at a clock edge SHALL force IDLE, out_valid=0, err=0, C_reg=0, clear all iteration counters and captured operands, and set in_ready=1 on the next cycle.
REQ-030 clear SHALL take priority over every other input in every state, including mid-mul/div (abort, no result) and DONE (result discarded).

Configuration
REQ-031 Macro SEQ_ALU_MULDIV_EN SHALL control the iterative datapath.
- Defined: mul/div behave per REQ-020..REQ-023.
- Undefined: the iterative datapath and BUSY state are omitted; mul and div behave as illegal opcodes per REQ-024. All other behaviour is identical.

Verification (WIDTH=32, SEQ_ALU_MULDIV_EN defined unless noted)
REQ-032 add A=7 B=5 -> one cycle after accept: out_valid=1, C_reg=64'h0000_0000_0000_000C, err=0; ror A=32'h8000_0001 B=1 -> LO=32'hC000_0000.
REQ-033 mul A=-3 B=5 -> out_valid exactly 33 cycles after accept, C_reg=64'hFFFF_FFFF_FFFF_FFF1.
REQ-034 div A=17 B=5 -> LO=3, HI=2.
- div A=-17 B=5 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFE.
- div A=9 B=0 -> one cycle later err=1, C_reg=64'h0000_0009_FFFF_FFFF.
REQ-035 Hold out_ready=0 for 5 cycles after any result -> C_reg/out_valid stable, in_ready=0.
- Then out_ready=1 for 1 cycle -> out_valid=0 and in_ready=1 on the next cycle.
REQ-036 Assert clear on cycle 10 of a mul -> next cycle out_valid=0, C_reg=0, in_ready=1.
- A new add 1+1 then returns LO=2.
REQ-037 SEQ_ALU_MULDIV_EN undefined, opcode 01110 -> one cycle later err=1, C_reg=0.
- Illegal opcode 11111 gives the same response in either build.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus optional iterative signed mul/div.
// Macro SEQ_ALU_MULDIV_EN enables the iterative datapath; without it mul/div are illegal opcodes.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A_reg,
  input  logic [WIDTH-1:0]     B_reg,
  input  logic [4:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   C_reg,
  output logic                 err
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] SH_ONE = 1;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;
`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = WIDTH;
  localparam logic [CW-1:0] CNT_ONE  = 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef SEQ_ALU_MULDIV_EN
    S_BUSY = 2'd1,
`endif
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 err_q, err_d;
  logic [2*WIDTH-1:0]   c_q, c_d;

  logic [SHW-1:0]       sh, nsh;
  logic [WIDTH-1:0]     alu_lo;
  logic                 alu_single;

  // Rotates use shift-by-(WIDTH-sh); sh=0 makes both halves equal to A, so OR is still A.
  always_comb begin
    sh         = B_reg[SHW-1:0];
    nsh        = ~sh + SH_ONE;
    alu_lo     = '0;
    alu_single = 1'b1;
    case (opcode)
      OP_ADD:  alu_lo = A_reg + B_reg;
      OP_SUB:  alu_lo = A_reg - B_reg;
      OP_SHR:  alu_lo = A_reg >> sh;
      OP_SHL:  alu_lo = A_reg << sh;
      OP_ROR:  alu_lo = (A_reg >> sh) | (A_reg << nsh);
      OP_ROL:  alu_lo = (A_reg << sh) | (A_reg >> nsh);
      OP_AND:  alu_lo = A_reg & B_reg;
      OP_OR:   alu_lo = A_reg | B_reg;
      OP_NEG:  alu_lo = -B_reg;
      OP_NOT:  alu_lo = ~B_reg;
      default: alu_single = 1'b0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d, dv_q, dv_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic [WIDTH:0]       step_sum;
  logic [WIDTH-1:0]     hi_nx, lo_nx, a_mag, b_mag;
  logic [2*WIDTH-1:0]   prod, fin;

  // Magnitude-based shift-add multiply / restoring divide; signs are applied on the last step.
  always_comb begin
    a_mag    = A_reg[WIDTH-1] ? -A_reg : A_reg;
    b_mag    = B_reg[WIDTH-1] ? -B_reg : B_reg;
    step_sum = '0;
    hi_nx    = hi_q;
    lo_nx    = lo_q;
    if (is_div_q) begin
      step_sum = {hi_q, lo_q[WIDTH-1]} - {1'b0, dv_q};
      if (!step_sum[WIDTH]) begin
        hi_nx = step_sum[WIDTH-1:0];
        lo_nx = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_nx = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
      hi_nx    = step_sum[WIDTH:1];
      lo_nx    = {step_sum[0], lo_q[WIDTH-1:1]};
    end
    prod = {hi_nx, lo_nx};
    if (is_div_q) fin = {(rneg_q ? -hi_nx : hi_nx), (qneg_q ? -lo_nx : lo_nx)};
    else          fin = qneg_q ? -prod : prod;
  end
`endif

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    c_d         = c_q;
`ifdef SEQ_ALU_MULDIV_EN
    hi_d        = hi_q;
    lo_d        = lo_q;
    dv_d        = dv_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          in_ready_d  = 1'b0;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          if (alu_single) begin
            c_d   = {{WIDTH{1'b0}}, alu_lo};
            err_d = 1'b0;
          end
`ifdef SEQ_ALU_MULDIV_EN
          else if (opcode == OP_DIV && B_reg == '0) begin
            c_d   = {A_reg, {WIDTH{1'b1}}};
            err_d = 1'b1;
          end
          else if (opcode == OP_MUL || opcode == OP_DIV) begin
            state_d     = S_BUSY;
            out_valid_d = 1'b0;
            err_d       = 1'b0;
            hi_d        = '0;
            lo_d        = a_mag;
            dv_d        = b_mag;
            cnt_d       = CNT_LOAD;
            is_div_d    = (opcode == OP_DIV);
            qneg_d      = A_reg[WIDTH-1] ^ B_reg[WIDTH-1];
            rneg_d      = A_reg[WIDTH-1];
          end
`endif
          else begin
            c_d   = '0;
            err_d = 1'b1;
          end
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      S_BUSY: begin
        hi_d  = hi_nx;
        lo_d  = lo_nx;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          c_d         = fin;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      c_q         <= '0;
`ifdef SEQ_ALU_MULDIV_EN
      hi_q        <= '0;
      lo_q        <= '0;
      dv_q        <= '0;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      c_q         <= c_d;
`ifdef SEQ_ALU_MULDIV_EN
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      dv_q        <= dv_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign C_reg     = c_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=32): driver pushes model results, monitor pops on out_valid.
// Mul/div expectations follow SEQ_ALU_MULDIV_EN as seen by this compilation.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        clear, in_valid, in_ready, out_valid, out_ready, err;
  logic [31:0] A_reg, B_reg;
  logic [4:0]  opcode;
  logic [63:0] C_reg;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .A_reg(A_reg), .B_reg(B_reg), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready), .C_reg(C_reg), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned edges = 0;
  always @(posedge clk) edges++;

  typedef struct {
    logic [63:0] c;
    logic        e;
    int          lat;
    int unsigned acc;
    int          hold;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: plain arithmetic on 32-bit values, 64-bit signed ints for mul/div.
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] c, output logic e, output int lat);
    logic [63:0] t;
    logic [31:0] lo;
    longint sa, sb, q, r;
    int sh;
    sh = int'(b[4:0]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lo = 32'h0; e = 1'b0; lat = 1; c = 64'h0;
    case (op)
      5'b00011: lo = a + b;
      5'b00100: lo = a - b;
      5'b00101: lo = a >> sh;
      5'b00110: lo = a << sh;
      5'b00111: begin t = {a, a} >> sh; lo = t[31:0]; end
      5'b01000: begin t = {a, a} << sh; lo = t[63:32]; end
      5'b01001: lo = a & b;
      5'b01010: lo = a | b;
      5'b10000: lo = 32'h0 - b;
      5'b10001: lo = ~b;
`ifdef SEQ_ALU_MULDIV_EN
      5'b01110: begin c = sa * sb; lat = 33; return; end
      5'b01111: begin
        if (b == 32'h0) begin c = {a, 32'hFFFF_FFFF}; e = 1'b1; return; end
        q = sa / sb; r = sa % sb;
        c = {r[31:0], q[31:0]}; lat = 33; return;
      end
`endif
      default: begin c = 64'h0; e = 1'b1; return; end
    endcase
    c = {32'h0, lo};
  endfunction

  // Monitor: compare on out_valid, stall for the requested hold, then complete the handshake.
  initial begin
    exp_t ex;
    logic [63:0] held;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && out_valid) begin
        if (sbq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_result: out_valid=1 C_reg=%h with nothing outstanding", C_reg);
          out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
        end else begin
          ex = sbq.pop_front();
          chk("latency", 64'(edges - ex.acc), 64'(ex.lat));
          chk("C_reg", C_reg, ex.c);
          chk("err", 64'(err), 64'(ex.e));
          held = C_reg;
          for (int i = 0; i < ex.hold; i++) begin
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_C_reg", C_reg, held);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
          end
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0;
          chk("post_out_valid", 64'(out_valid), 64'd0);
          chk("post_in_ready", 64'(in_ready), 64'd1);
        end
      end
    end
  end

  // Driver: called on a negedge; returns on the negedge after the accepting edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t ex;
    int t;
    t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout: in_ready=%0b required 1", in_ready);
      return;
    end
    model(op, a, b, ex.c, ex.e, ex.lat);
    ex.hold = hold;
    ex.acc  = edges;
    sbq.push_back(ex);
    opcode = op; A_reg = a; B_reg = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    opcode = 5'($urandom); A_reg = $urandom; B_reg = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sbq.size() != 0 || !in_ready) && t < 300) begin @(negedge clk); t++; end
    chk("drain_outstanding", 64'(sbq.size()), 64'd0);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0] ops [13];
    logic [4:0] op;
    int idx;
    bit seen;
    ops = '{5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h0E, 5'h0F, 5'h10, 5'h11, 5'h1F};
    clear = 1'b1; in_valid = 1'b0; A_reg = '0; B_reg = '0; opcode = '0;
    @(negedge clk); @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_C_reg", C_reg, 64'h0);
    clear = 1'b0;
    mon_en = 1'b1;

    issue(5'b00011, 32'd7, 32'd5, 5);
    issue(5'b00111, 32'h8000_0001, 32'd1, 0);
    issue(5'b01110, 32'hFFFF_FFFD, 32'd5, 1);
    issue(5'b01111, 32'd17, 32'd5, 0);
    issue(5'b01111, 32'hFFFF_FFEF, 32'd5, 5);
    issue(5'b01111, 32'd9, 32'd0, 0);
    issue(5'b01111, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(5'b01110, 32'h8000_0000, 32'h8000_0000, 0);
    issue(5'b11111, 32'd3, 32'd4, 2);
    issue(5'b00000, 32'd3, 32'd4, 0);
    issue(5'b00100, 32'd0, 32'd1, 0);
    issue(5'b00011, 32'hFFFF_FFFF, 32'd1, 0);
    issue(5'b00101, 32'h8000_0000, 32'd31, 0);
    issue(5'b00110, 32'h0000_0001, 32'h0000_0020, 0);
    issue(5'b01000, 32'h8000_0001, 32'd4, 0);
    issue(5'b10000, 32'd0, 32'd1, 0);
    issue(5'b10001, 32'd0, 32'h0F0F_0F0F, 0);

    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 12);
      op = ops[idx];
      if (idx == 12) op = 5'd24 + 5'($urandom_range(0, 7));
      issue(op, pick_val(), pick_val(), $urandom_range(0, 2));
    end
    drain();

    // Clear in the middle of a multiply (or of a DONE state in the reduced build).
    mon_en = 1'b0;
    opcode = 5'b01110; A_reg = 32'd1234; B_reg = 32'd777; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_out_valid", 64'(out_valid), 64'd0);
    chk("clear_C_reg", C_reg, 64'h0);
    chk("clear_in_ready", 64'(in_ready), 64'd1);
    chk("clear_err", 64'(err), 64'd0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    chk("no_result_after_clear", 64'(seen), 64'd0);

    // Clear while a result waits in DONE.
    opcode = 5'b01010; A_reg = 32'hF0; B_reg = 32'h0F; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_done_out_valid", 64'(out_valid), 64'd0);
    chk("clear_done_C_reg", C_reg, 64'h0);

    mon_en = 1'b1;
    issue(5'b00011, 32'd1, 32'd1, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
